// File: rtl/music_pkg.sv
// Shared constants for the music playback datapath: score width,
// scheduler state encodings and the WAIT_START timeout.
package music_pkg;

    localparam int unsigned ScoreBits   = 2;

    // Cycles the scheduler waits for the reader to leave idle before
    // treating the score as empty.
    localparam int unsigned WaitTimeout = 4;
    localparam int unsigned WaitBits    = $clog2(WaitTimeout);

    localparam logic [2:0] StIdle      = 3'd0;
    localparam logic [2:0] StLaunch    = 3'd1;
    localparam logic [2:0] StWaitStart = 3'd2;
    localparam logic [2:0] StPlaying   = 3'd3;
    localparam logic [2:0] StGap       = 3'd4;

endpackage

// File: rtl/score_request_fifo.sv
// Request FIFO for queued score indices. Flush has priority over push and
// pop; a push while full is accepted only when a pop frees a slot in the
// same cycle.
module score_request_fifo #(
    parameter int unsigned Depth    = 4,
    parameter int unsigned DataBits = 2
) (
    input  logic                      CLK,
    input  logic                      RESET,
    input  logic                      push,
    input  logic                      pop,
    input  logic                      flush,
    input  logic [DataBits-1:0]       dataIn,
    output logic [DataBits-1:0]       head,
    output logic                      full,
    output logic                      empty,
    output logic [$clog2(Depth):0]    count
);

    localparam int unsigned PtrBits   = $clog2(Depth);
    localparam int unsigned CountBits = PtrBits + 1;

    logic [DataBits-1:0] mem [Depth];
    logic [PtrBits-1:0]  rdPtr;
    logic [PtrBits-1:0]  wrPtr;
    logic                doPush;
    logic                doPop;

    assign empty  = (count == '0);
    assign full   = (count == CountBits'(Depth));
    assign doPop  = pop && !empty;
    assign doPush = push && (!full || doPop);
    assign head   = mem[rdPtr];

    // Storage write; contents need no reset since count gates validity
    always_ff @(posedge CLK) begin
        if (doPush && !flush)
            mem[wrPtr] <= dataIn;
    end

    // Pointer and occupancy bookkeeping
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            rdPtr <= '0;
            wrPtr <= '0;
            count <= '0;
        end else if (flush) begin
            rdPtr <= '0;
            wrPtr <= '0;
            count <= '0;
        end else begin
            if (doPush)
                wrPtr <= wrPtr + 1'b1;
            if (doPop)
                rdPtr <= rdPtr + 1'b1;
            if (doPush && !doPop)
                count <= count + 1'b1;
            else if (doPop && !doPush)
                count <= count - 1'b1;
        end
    end

endmodule

// File: rtl/score_play_scheduler.sv
// Sequences queued score-play requests onto the shared music datapath:
// launch, wait for the reader to start, play, silent gap, next request.
// Stop aborts the current score and flushes the queue.
module score_play_scheduler
    import music_pkg::*;
#(
    parameter int unsigned QueueDepth = 4,
    parameter int unsigned GapCycles  = 25000000,
    parameter int unsigned GapBits    = 25
) (
    input  logic                          CLK,
    input  logic                          RESET,
    input  logic                          Request,
    input  logic [ScoreBits-1:0]          ScoreSelectIn,
    input  logic                          Stop,
    input  logic                          EndofScore,
    output logic                          StartPlay,
    output logic [ScoreBits-1:0]          ScoreSelect,
    output logic                          PlayEnable,
    output logic                          ReaderAbort,
    output logic                          Busy,
    output logic [$clog2(QueueDepth):0]   QueueCount,
    output logic                          Dropped
);

    localparam logic [GapBits-1:0] GapLast = GapBits'(GapCycles - 1);

    logic [2:0]           state;
    logic [2:0]           nextState;
    logic [WaitBits-1:0]  waitCnt;
    logic [GapBits-1:0]   gapCnt;
    logic                 gapDone;
    logic                 pop;
    logic                 push;
    logic                 fifoFull;
    logic                 fifoEmpty;
    logic [ScoreBits-1:0] fifoHead;

    // Popping happens exactly on the edge that enters LAUNCH
    assign pop  = (nextState == StLaunch);
    assign push = Request && !Stop;

    score_request_fifo #(
        .Depth    (QueueDepth),
        .DataBits (ScoreBits)
    ) requestFifo (
        .CLK    (CLK),
        .RESET  (RESET),
        .push   (push),
        .pop    (pop),
        .flush  (Stop),
        .dataIn (ScoreSelectIn),
        .head   (fifoHead),
        .full   (fifoFull),
        .empty  (fifoEmpty),
        .count  (QueueCount)
    );

    // Next-state decode; Stop overrides every transition
    always_comb begin
        nextState = state;
        case (state)
            StIdle:
                if (!fifoEmpty)
                    nextState = StLaunch;
            StLaunch:
                nextState = StWaitStart;
            StWaitStart:
                if (!EndofScore)
                    nextState = StPlaying;
                else if (waitCnt == WaitBits'(WaitTimeout - 1))
                    nextState = StGap;
            StPlaying:
                if (EndofScore)
                    nextState = StGap;
            StGap:
                if (gapDone)
                    nextState = fifoEmpty ? StIdle : StLaunch;
            default:
                nextState = StIdle;
        endcase
        if (Stop)
            nextState = StIdle;
    end

    // State register
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET)
            state <= StIdle;
        else
            state <= nextState;
    end

    // Cycles spent in WAIT_START, restarted on every entry
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET)
            waitCnt <= '0;
        else if (state != StWaitStart)
            waitCnt <= '0;
        else
            waitCnt <= waitCnt + 1'b1;
    end

    // Gap timer: GapCycles counted silent cycles followed by one cycle in
    // which the registered terminal flag makes the launch/idle decision,
    // so the next launch lands GapCycles+1 cycles after GAP is entered.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            gapCnt  <= '0;
            gapDone <= 1'b0;
        end else if (Stop || state != StGap) begin
            gapCnt  <= '0;
            gapDone <= 1'b0;
        end else if (gapCnt == GapLast) begin
            gapDone <= 1'b1;
        end else begin
            gapCnt  <= gapCnt + 1'b1;
        end
    end

    // Score index latched from the queue head at launch; Stop leaves it alone
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET)
            ScoreSelect <= '0;
        else if (pop)
            ScoreSelect <= fifoHead;
    end

    // Single-cycle abort and overflow pulses
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            ReaderAbort <= 1'b0;
            Dropped     <= 1'b0;
        end else begin
            ReaderAbort <= Stop && (state != StIdle);
            Dropped     <= Request && !Stop && fifoFull && !pop;
        end
    end

    assign StartPlay  = (state == StLaunch);
    assign PlayEnable = (state == StWaitStart) || (state == StPlaying);
    assign Busy       = (state != StIdle);

endmodule

// File: tb/tb_score_play_scheduler.sv
// Self-checking bench for score_play_scheduler: directed scenarios followed
// by a randomized phase, all compared each cycle against a queue-based
// reference model with countdown timers.
module tb_score_play_scheduler;

    localparam int unsigned QD  = 4;
    localparam int unsigned GAP = 8;

    logic       CLK;
    logic       RESET;
    logic       Request;
    logic [1:0] ScoreSelectIn;
    logic       Stop;
    logic       EndofScore;
    logic       StartPlay;
    logic [1:0] ScoreSelect;
    logic       PlayEnable;
    logic       ReaderAbort;
    logic       Busy;
    logic [2:0] QueueCount;
    logic       Dropped;

    int nAsserts = 0;
    int nFail    = 0;

    typedef enum int {M_IDLE, M_START, M_WAIT, M_PLAY, M_GAP} mode_t;
    mode_t mode;
    int    waitLeft;
    int    gapLeft;
    int    q[$];
    int    expSel;
    bit    expAbort;
    bit    expDropped;

    bit    readerOn;
    bit    readerRandom;
    int    readerLen;
    int    rdLeft;
    int    launched[$];
    int    dropSeen;

    score_play_scheduler #(
        .QueueDepth (QD),
        .GapCycles  (GAP),
        .GapBits    (4)
    ) dut (
        .CLK           (CLK),
        .RESET         (RESET),
        .Request       (Request),
        .ScoreSelectIn (ScoreSelectIn),
        .Stop          (Stop),
        .EndofScore    (EndofScore),
        .StartPlay     (StartPlay),
        .ScoreSelect   (ScoreSelect),
        .PlayEnable    (PlayEnable),
        .ReaderAbort   (ReaderAbort),
        .Busy          (Busy),
        .QueueCount    (QueueCount),
        .Dropped       (Dropped)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nAsserts++;
        assert (obs === exp) else begin
            nFail++;
            $error("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic modelReset();
        mode       = M_IDLE;
        waitLeft   = 0;
        gapLeft    = 0;
        q.delete();
        expSel     = 0;
        expAbort   = 0;
        expDropped = 0;
    endtask

    // Reference behaviour for one clock edge, using pre-edge inputs
    task automatic modelStep();
        bit popNow;
        if (!RESET) begin
            modelReset();
            return;
        end
        expAbort   = Stop && (mode != M_IDLE);
        expDropped = 0;
        popNow     = 0;
        if (Stop) begin
            q.delete();
            mode = M_IDLE;
        end else begin
            case (mode)
                M_IDLE:
                    if (q.size() > 0) begin
                        mode   = M_START;
                        popNow = 1;
                    end
                M_START: begin
                    mode     = M_WAIT;
                    waitLeft = 4;
                end
                M_WAIT: begin
                    waitLeft--;
                    if (!EndofScore)
                        mode = M_PLAY;
                    else if (waitLeft == 0) begin
                        mode    = M_GAP;
                        gapLeft = GAP + 1;
                    end
                end
                M_PLAY:
                    if (EndofScore) begin
                        mode    = M_GAP;
                        gapLeft = GAP + 1;
                    end
                M_GAP: begin
                    gapLeft--;
                    if (gapLeft == 0) begin
                        if (q.size() > 0) begin
                            mode   = M_START;
                            popNow = 1;
                        end else
                            mode = M_IDLE;
                    end
                end
                default: mode = M_IDLE;
            endcase
            if (popNow)
                expSel = q.pop_front();
            if (Request) begin
                if (q.size() < QD)
                    q.push_back(int'(ScoreSelectIn));
                else
                    expDropped = 1;
            end
        end
    endtask

    task automatic checkOutputs();
        chk("StartPlay",   StartPlay,   mode == M_START);
        chk("ScoreSelect", ScoreSelect, expSel);
        chk("PlayEnable",  PlayEnable,  (mode == M_WAIT) || (mode == M_PLAY));
        chk("ReaderAbort", ReaderAbort, expAbort);
        chk("Busy",        Busy,        mode != M_IDLE);
        chk("QueueCount",  QueueCount,  q.size());
        chk("Dropped",     Dropped,     expDropped);
    endtask

    task automatic checkReset(input string tag);
        chk({tag, "_StartPlay"},   StartPlay,   0);
        chk({tag, "_ScoreSelect"}, ScoreSelect, 0);
        chk({tag, "_PlayEnable"},  PlayEnable,  0);
        chk({tag, "_ReaderAbort"}, ReaderAbort, 0);
        chk({tag, "_Busy"},        Busy,        0);
        chk({tag, "_QueueCount"},  QueueCount,  0);
        chk({tag, "_Dropped"},     Dropped,     0);
    endtask

    // One clock: model follows the edge, outputs checked at the falling edge,
    // then the emulated reader and the pulse inputs are updated.
    task automatic tick();
        @(posedge CLK);
        modelStep();
        @(negedge CLK);
        checkOutputs();
        if (StartPlay)
            launched.push_back(int'(ScoreSelect));
        if (Dropped)
            dropSeen++;
        if (readerOn) begin
            if (ReaderAbort)
                rdLeft = 0;
            else if (StartPlay) begin
                if (readerRandom)
                    rdLeft = ($urandom_range(0, 3) == 0) ? 0 : int'($urandom_range(1, 12));
                else
                    rdLeft = readerLen;
            end else if (rdLeft > 0)
                rdLeft--;
            EndofScore = (rdLeft == 0);
        end
        Request = 1'b0;
        Stop    = 1'b0;
    endtask

    task automatic request(input int sel);
        Request       = 1'b1;
        ScoreSelectIn = 2'(sel);
        tick();
    endtask

    task automatic waitGap(input string tag);
        int k;
        k = 0;
        while (PlayEnable !== 1'b0 && k < 200) begin
            tick();
            k++;
        end
        chk(tag, PlayEnable, 0);
    endtask

    initial begin
        int exp3[3];
        exp3 = '{0, 1, 3};

        RESET         = 1'b0;
        Request       = 1'b0;
        Stop          = 1'b0;
        ScoreSelectIn = '0;
        EndofScore    = 1'b1;
        readerOn      = 1;
        readerRandom  = 0;
        readerLen     = 5;
        rdLeft        = 0;
        dropSeen      = 0;
        modelReset();
        #2;
        checkReset("por");
        @(negedge CLK);
        RESET = 1'b1;

        // Single request, score 2
        request(2);
        repeat (25) tick();
        chk("single_busy_end", Busy, 0);
        chk("single_launch", launched.size() > 0 ? launched[0] : -1, 2);

        // Back-to-back: 1 and 3 queued while 0 plays
        launched.delete();
        request(0);
        tick();
        tick();
        request(1);
        request(3);
        repeat (60) tick();
        chk("b2b_launches", launched.size(), 3);
        for (int i = 0; i < 3; i++)
            chk("b2b_order", i < launched.size() ? launched[i] : -1, exp3[i]);

        // Overflow while playing a long score
        readerLen = 30;
        dropSeen  = 0;
        request(1);
        tick();
        tick();
        for (int i = 0; i < 5; i++)
            request(i);
        chk("ovf_count", QueueCount, 4);
        chk("ovf_drops", dropSeen, 1);
        waitGap("ovf_wait_gap");
        repeat (GAP) tick();
        dropSeen = 0;
        request(2);
        chk("ovf_pop_start", StartPlay, 1);
        chk("ovf_pop_count", QueueCount, 4);
        chk("ovf_pop_nodrop", Dropped, 0);

        // Stop mid-PLAYING with a full queue
        repeat (3) tick();
        Stop = 1'b1;
        tick();
        chk("stop_busy", Busy, 0);
        chk("stop_abort", ReaderAbort, 1);
        chk("stop_count", QueueCount, 0);
        chk("stop_playen", PlayEnable, 0);
        tick();
        chk("stop_abort_end", ReaderAbort, 0);
        Stop = 1'b1;
        request(3);
        chk("stopreq_count", QueueCount, 0);
        chk("stopreq_nodrop", Dropped, 0);
        tick();
        chk("stopreq_idle", Busy, 0);

        // Empty scores: reader never leaves idle
        readerLen = 0;
        launched.delete();
        request(1);
        request(3);
        repeat (40) tick();
        chk("empty_launches", launched.size(), 2);
        chk("empty_idle", Busy, 0);

        // Async reset mid-GAP with three queued
        readerLen = 6;
        request(0);
        tick();
        request(1);
        request(2);
        request(3);
        waitGap("rst_wait_gap");
        repeat (3) tick();
        #2;
        RESET = 1'b0;
        #1;
        checkReset("async_rst");
        modelReset();
        rdLeft     = 0;
        EndofScore = 1'b1;
        @(negedge CLK);
        RESET = 1'b1;
        launched.delete();
        repeat (20) tick();
        chk("rst_no_start", launched.size(), 0);

        // Randomized traffic
        readerRandom = 1;
        for (int i = 0; i < 1500; i++) begin
            Request       = ($urandom_range(0, 4) == 0);
            ScoreSelectIn = 2'($urandom);
            Stop          = ($urandom_range(0, 79) == 0);
            tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", nAsserts, nFail);
        $finish;
    end

endmodule
